// File: rtl/load_store_unit.sv
// Byte-addressed load/store bridge onto a word-addressed memory port.
// Optional: define LSU_ALIGN_CHECK_EN to flag misaligned half/word accesses.
module load_store_unit #(
  parameter int MEM_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] ddatain,
  input  logic [31:0] ddataout
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, WRITE, RESP
  } state_t;

  state_t      state, state_nx;
  logic        we_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic        accept, bad, mis, word_st;
  logic [29:0] widx;
  logic [1:0]  lane_in;
  logic [4:0]  sh;
  logic [31:0] lane_word, load_val;
  logic [31:0] mask, merged;

  assign accept    = req_valid & req_ready;
  assign req_ready = (state == IDLE) & rst;
  assign rsp_valid = (state == RESP);
  assign widx      = req_addr[31:2];
  assign word_st   = req_we & (req_size == 2'd2);

  // Request validity: bad size, out-of-range word, optional misalignment
  always_comb begin
    mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mis = ((req_size == 2'd1) && req_addr[0]) ||
          ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
`endif
    bad = (req_size == 2'd3) ||
          ((widx >> MEM_WIDTH) != '0) || mis;
  end

  // Lane select with misaligned offsets forced to natural alignment
  always_comb begin
    unique case (req_size)
      2'd1:    lane_in = {req_addr[1], 1'b0};
      2'd2:    lane_in = 2'b00;
      default: lane_in = req_addr[1:0];
    endcase
  end

  // Load extension and sub-word store merge from the read word
  always_comb begin
    sh        = {lane_q, 3'b000};
    lane_word = ddataout >> sh;
    unique case (size_q)
      2'd0: load_val = {{24{~uns_q & lane_word[7]}},
                        lane_word[7:0]};
      2'd1: load_val = {{16{~uns_q & lane_word[15]}},
                        lane_word[15:0]};
      default: load_val = ddataout;
    endcase
    mask   = ((size_q == 2'd0) ? 32'h0000_00FF
                               : 32'h0000_FFFF) << sh;
    merged = (ddataout & ~mask) | ((ddatain << sh) & mask);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = bad ? RESP : ISSUE;
      ISSUE:   state_nx = (we_q && size_q == 2'd2) ? RESP
                                                    : WAIT;
      WAIT:    state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, memory port and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      lane_q    <= 2'd0;
      dwe       <= 1'b0;
      daddr     <= '0;
      ddatain   <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      dwe <= 1'b0;
      if (state == IDLE && accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        lane_q <= lane_in;
        if (bad) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          dwe     <= word_st;
          daddr   <= {2'b00, widx};
          ddatain <= req_wdata;
        end
      end
      if (state == ISSUE && we_q && size_q == 2'd2) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
      if (state == WAIT) begin
        if (we_q) begin
          ddatain <= merged;
          dwe     <= 1'b1;
        end else begin
          rsp_err   <= 1'b0;
          rsp_rdata <= load_val;
        end
      end
      if (state == WRITE) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1-cycle registered memory.
// Expectations follow LSU_ALIGN_CHECK_EN when it is defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, dwe;
  logic [31:0] rsp_rdata, daddr, ddatain, ddataout;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:65535];
  int          dwe_cnt = 0;
  logic [31:0] wd_last = '0;

  load_store_unit #(.MEM_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .dwe(dwe), .daddr(daddr), .ddatain(ddatain),
    .ddataout(ddataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dwe) begin
      mem[daddr[15:0]] <= ddatain;
      dwe_cnt <= dwe_cnt + 1;
      wd_last <= ddatain;
    end
    ddataout <= mem[daddr[15:0]];
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we,
                        input logic [1:0] size,
                        input logic uns,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata,
                        output logic err,
                        output int lat,
                        output int nwr,
                        output logic dwe1,
                        output logic rdy);
    int base;
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int i = 0; i < 10 && !req_ready; i++)
      @(negedge clk);
    base = dwe_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'd3;
    req_unsigned = ~uns; req_addr = '1;
    req_wdata = 32'hA5A5_A5A5;
    lat = 99; rdy = 1'b0; dwe1 = 1'b0;
    rdata = '0; err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) dwe1 = dwe;
      if (req_ready) rdy = 1'b1;
      if (rsp_valid) begin
        lat = c; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    nwr = dwe_cnt - base;
  endtask

  task automatic expect_req(input string tag,
                            input logic we,
                            input logic [1:0] size,
                            input logic uns,
                            input logic [31:0] addr,
                            input logic [31:0] wdata,
                            input logic [31:0] e_rd,
                            input logic e_err,
                            input int e_lat,
                            input int e_nwr);
    logic [31:0] rd;
    logic        er, d1, rdy;
    int          lat, nwr;
    do_req(we, size, uns, addr, wdata,
           rd, er, lat, nwr, d1, rdy);
    check({tag, " rdata"}, rd, e_rd);
    check({tag, " err"}, 32'(er), 32'(e_err));
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " writes"}, 32'(nwr), 32'(e_nwr));
    check({tag, " ready busy"}, 32'(rdy), 32'd0);
  endtask

  logic [31:0] rd, dsave;
  logic        er, d1, rdy, saw;
  int          lat, nwr, base;

  initial begin
    mem[16'h0010] = 32'h8765_43A1;
    mem[16'hFFFF] = 32'hCAFE_F00D;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    check("rst dwe", 32'(dwe), 32'd0);
    check("rst daddr", daddr, 32'd0);
    check("rst ddatain", ddatain, 32'd0);
    check("rst ready low", 32'(req_ready), 32'd0);
    rst = 1'b1; #1;
    check("ready after rst", 32'(req_ready), 32'd1);
    @(negedge clk);

    expect_req("lb 40", 0, 0, 0, 32'h40, 0,
               32'hFFFF_FFA1, 0, 3, 0);
    expect_req("lbu 43", 0, 0, 1, 32'h43, 0,
               32'h0000_0087, 0, 3, 0);
    expect_req("lb 41", 0, 0, 0, 32'h41, 0,
               32'h0000_0043, 0, 3, 0);
    expect_req("lh 42", 0, 1, 0, 32'h42, 0,
               32'hFFFF_8765, 0, 3, 0);
    expect_req("lhu 40", 0, 1, 1, 32'h40, 0,
               32'h0000_43A1, 0, 3, 0);

    expect_req("sh 42", 1, 1, 0, 32'h42, 32'hDEAD_BEEF,
               32'h0, 0, 4, 1);
    check("sh 42 wdata", wd_last, 32'hBEEF_43A1);
    check("sh 42 mem", mem[16'h0010], 32'hBEEF_43A1);
    expect_req("lw 40a", 0, 2, 0, 32'h40, 0,
               32'hBEEF_43A1, 0, 3, 0);

    expect_req("sb 41", 1, 0, 0, 32'h41, 32'hCAFE_1255,
               32'h0, 0, 4, 1);
    check("sb 41 wdata", wd_last, 32'hBEEF_55A1);

    do_req(1, 2, 0, 32'h0, 32'h1234_5678,
           rd, er, lat, nwr, d1, rdy);
    check("sw 0 latency", 32'(lat), 32'd2);
    check("sw 0 dwe c1", 32'(d1), 32'd1);
    check("sw 0 writes", 32'(nwr), 32'd1);
    check("sw 0 ready busy", 32'(rdy), 32'd0);
    check("sw 0 err", 32'(er), 32'd0);
    check("sw 0 rdata", rd, 32'd0);
    check("sw 0 mem", mem[0], 32'h1234_5678);
    expect_req("lw 0", 0, 2, 0, 32'h0, 0,
               32'h1234_5678, 0, 3, 0);

`ifdef LSU_ALIGN_CHECK_EN
    expect_req("lhu 41", 0, 1, 1, 32'h41, 0,
               32'h0, 1, 1, 0);
    expect_req("lw 42", 0, 2, 0, 32'h42, 0,
               32'h0, 1, 1, 0);
    expect_req("sw 43", 1, 2, 0, 32'h43, 32'h1,
               32'h0, 1, 1, 0);
`else
    expect_req("lhu 41", 0, 1, 1, 32'h41, 0,
               32'h0000_55A1, 0, 3, 0);
    expect_req("lw 42", 0, 2, 0, 32'h42, 0,
               32'hBEEF_55A1, 0, 3, 0);
`endif

    dsave = daddr;
    expect_req("lw range", 0, 2, 0, 32'h0004_0000, 0,
               32'h0, 1, 1, 0);
    check("range daddr", daddr, dsave);
    expect_req("lw top", 0, 2, 0, 32'h0003_FFFC, 0,
               32'hCAFE_F00D, 0, 3, 0);
    expect_req("size3 ld", 0, 3, 0, 32'h40, 0,
               32'h0, 1, 1, 0);
    expect_req("size3 st", 1, 3, 0, 32'h40, 32'h9,
               32'h0, 1, 1, 0);
    check("size3 mem", mem[16'h0010], 32'hBEEF_55A1);

    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h77;
    req_valid = 1'b1;
    for (int i = 0; i < 10 && !req_ready; i++)
      @(negedge clk);
    base = dwe_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst6 dwe in write", 32'(dwe), 32'd1);
    check("rst6 merged", ddatain, 32'hBEEF_5577);
    rst = 1'b0; #1;
    check("rst6 dwe async", 32'(dwe), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
      if (i == 3) rst = 1'b1;
    end
    check("rst6 no rsp", 32'(saw), 32'd0);
    check("rst6 no write", 32'(dwe_cnt - base), 32'd0);
    check("rst6 mem", mem[16'h0010], 32'hBEEF_55A1);
    expect_req("lw after rst", 0, 2, 0, 32'h40, 0,
               32'hBEEF_55A1, 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
